// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Load/store data-memory responder with valid/ready request and
//               response handshakes, programmable wait states and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_store_type,
    input  logic [2:0]  req_load_type,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_aw    = $clog2(DEPTH_WORDS);
    localparam logic [29:0] c_depth = 30'(DEPTH_WORDS);
    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [3:0]      r_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_write;
    logic [1:0]      r_store_type;
    logic [2:0]      r_load_type;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_size_half;
    logic            w_size_word;
    logic            w_type_bad;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_err;
    logic [c_aw-1:0] w_idx;
    logic [31:0]     w_mem_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_data;
    logic [31:0]     w_wr_word;

    assign w_accept     = req_valid && req_ready;
    // Latency is WAIT_CYCLES+1 edges, so the counter holds WAIT_CYCLES and
    // every request passes through WAIT at least once.
    assign w_enter_resp = (r_state == c_st_wait) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept)           w_next_state = c_st_wait;
            c_st_wait: if (r_cnt == 4'd0)      w_next_state = c_st_resp;
            c_st_resp: if (rsp_ready)          w_next_state = c_st_idle;
            default:                           w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready = (r_state == c_st_idle) && rst;
        rsp_valid = (r_state == c_st_resp);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_write      <= 1'b0;
            r_store_type <= 2'd0;
            r_load_type  <= 3'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= req_addr;
                r_wdata      <= req_wdata;
                r_write      <= req_write;
                r_store_type <= req_store_type;
                r_load_type  <= req_load_type;
                r_cnt        <= c_wait;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? 32'd0 : w_load_data;
            end
        end
    end

    // Only the type field matching the direction is decoded.
    always_comb begin
        w_size_half = 1'b0;
        w_size_word = 1'b0;
        w_type_bad  = 1'b0;
        if (r_write) begin
            case (r_store_type)
                2'b00:   ;
                2'b01:   w_size_half = 1'b1;
                2'b10:   w_size_word = 1'b1;
                default: w_type_bad  = 1'b1;
            endcase
        end else begin
            case (r_load_type)
                3'b000, 3'b100: ;
                3'b001, 3'b101: w_size_half = 1'b1;
                3'b010:         w_size_word = 1'b1;
                default:        w_type_bad  = 1'b1;
            endcase
        end
    end

    assign w_misaligned   = (w_size_half && r_addr[0]) ||
                            (w_size_word && (r_addr[1:0] != 2'b00));
    assign w_out_of_range = (r_addr[31:2] >= c_depth);
    assign w_err          = w_type_bad || w_misaligned || w_out_of_range;

    assign w_idx      = r_addr[c_aw+1:2];
    assign w_mem_word = r_mem[w_idx];
    assign w_byte     = w_mem_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = r_addr[1] ? w_mem_word[31:16] : w_mem_word[15:0];

    always_comb begin
        case (r_load_type)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_mem_word;
        endcase
    end

    always_comb begin
        w_wr_word = w_mem_word;
        case (r_store_type)
            2'b00: w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_addr[1]) begin
                    w_wr_word[31:16] = r_wdata[15:0];
                end else begin
                    w_wr_word[15:0]  = r_wdata[15:0];
                end
            end
            default: w_wr_word = r_wdata;
        endcase
    end

    // Array has no reset; commit is blocked under reset because r_state is IDLE.
    always_ff @(posedge clk) begin
        if (w_enter_resp && r_write && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

endmodule
`default_nettype wire
